imem_dmem_port_arbiter: RTL and testbench
=========================================

Name: imem_dmem_port_arbiter

Overview:
- Shares one single-port unified memory between instruction fetch (port F) and load/store (port D) for the multi-cycle build of the core.
- Sequences each access, grants on round-robin when both ports request, and drives the 2:1 address/data select (grant_sel) into the memory-side datapath mux.
- Returns read data and a one-cycle ready pulse to the winning requester.

Parameters:
- AW, 32, address width
- DW, 32, data width
- MEM_LAT, 1, memory read latency in cycles from the mem_en cycle to mem_rdata valid; legal range 1..7

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- f_req  in  1  fetch request; held until f_ready
- f_addr  in  AW  fetch address
- f_ready  out  1  one-cycle completion pulse to fetch
- f_rdata  out  DW  fetch read data
- d_req  in  1  load/store request; held until d_ready
- d_we  in  1  1 = store, 0 = load
- d_addr  in  AW  load/store address
- d_wdata  in  DW  store data
- d_ready  out  1  one-cycle completion pulse to load/store
- d_rdata  out  DW  load read data
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data
- grant_sel  out  1  0 = F owns the port, 1 = D owns the port
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (asynchronous, rst_n low) sets:
  - state = IDLE, last_grant = 1 (D), so F wins the first tie.
  - All outputs = 0: f_ready, d_ready, f_rdata, d_rdata, mem_en, mem_we, mem_addr, mem_wdata, grant_sel, busy.
- States: IDLE, ISSUE, WAIT, RESP. All outputs are registered.
- IDLE:
  - Neither port requesting: stay in IDLE.
  - Only one port requesting: grant that port.
  - Both requesting: grant the port opposite last_grant.
  - On a grant: latch addr/we/wdata (F forces we = 0, wdata = 0), set grant_sel and last_grant to the winner, go to ISSUE.
- ISSUE (exactly 1 cycle):
  - mem_en = 1; mem_we, mem_addr, mem_wdata come from the latched values.
  - Load latency counter with MEM_LAT-1; go to WAIT.
- WAIT:
  - mem_en = 0, mem_we = 0; mem_addr and mem_wdata hold their values.
  - Decrement the counter each cycle.
  - When the counter = 0, capture mem_rdata into the winner's rdata register, then go to RESP.
  - The capture edge is the edge ending the cycle that is MEM_LAT cycles after the ISSUE cycle.
- RESP (1 cycle):
  - Winner's ready = 1; next state is IDLE.
  - Stores still pulse ready; their rdata register is not updated.
- Latency: req seen in IDLE at cycle t gives ISSUE at t+1 and ready at t+2+MEM_LAT. New arbitration is earliest at t+3+MEM_LAT.
- f_rdata and d_rdata hold their last value until the next completed load by the same port.
- grant_sel holds from ISSUE through RESP; in IDLE it keeps the last winner.
- busy = 1 in ISSUE, WAIT and RESP.
- Requester protocol:
  - req, addr, we and wdata are sampled only in IDLE.
  - A request dropped mid-transaction does not abort it; ready still pulses.
  - A port that keeps req high after its ready is re-arbitrated as a new request.
- Starvation bound: with both ports requesting continuously, grants strictly alternate F, D, F, D.
- Reset mid-transaction: immediate abort, no ready pulse, arbitration restarts with F preferred.

Test Plan:
1. MEM_LAT=1, F-only load: f_req=1, f_addr=0x100 at cycle 0; memory returns 0xDEADBEEF at cycle 2 → mem_en=1, mem_we=0, mem_addr=0x100 at cycle 1; f_ready=1 at cycle 3 only; f_rdata=0xDEADBEEF; grant_sel=0.
2. D store: d_req=1, d_we=1, d_addr=0x2000, d_wdata=0x12345678 → one mem_en cycle with mem_we=1, mem_addr=0x2000, mem_wdata=0x12345678; d_ready pulses once; d_rdata unchanged.
3. Tie after reset, both ports held continuously for 4 transactions → grant order F, D, F, D; grant_sel = 0, 1, 0, 1; exactly one ready pulse per transaction, never both in the same cycle.
4. MEM_LAT=3, D load at cycle 0, memory returns 0xCAFEF00D at cycle 4 → d_ready at cycle 5; d_rdata=0xCAFEF00D; busy high for cycles 1–5.
5. rst_n low during WAIT → all outputs 0 immediately; no ready pulse after release; a subsequent tie grants F first.
6. f_req dropped at the ISSUE cycle → f_ready still pulses at t+2+MEM_LAT; no second mem_en without a new request.

Source files
------------

// File: rtl/imem_dmem_port_arbiter.sv
// imem_dmem_port_arbiter
//   Shares one single-port unified memory between instruction fetch (F) and
//   load/store (D). Each access runs IDLE -> ISSUE -> WAIT -> RESP; ties are
//   resolved round-robin (F wins the first tie after reset).
//
// Ports:
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   f_req/f_addr            fetch request (held until f_ready) and address
//   f_ready/f_rdata         one-cycle completion pulse and fetch read data
//   d_req/d_we/d_addr/d_wdata  load/store request, 1 = store, address, data
//   d_ready/d_rdata         one-cycle completion pulse and load read data
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata  memory-side interface
//   grant_sel               0 = F owns the memory port, 1 = D owns it
//   busy                    high whenever the sequencer is not IDLE
//
// Parameters: AW address width, DW data width, MEM_LAT read latency (1..7)
// from the mem_en cycle to mem_rdata valid.
module imem_dmem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_ready,
  output logic [DW-1:0] f_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ready,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          grant_sel,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [2:0] CNT_LOAD = 3'(MEM_LAT - 1);

  state_t     state, state_nxt;
  logic       last_grant;   // 1 = D won most recently
  logic       we_q;         // latched store flag of the current access
  logic [2:0] cnt;

  logic grant;              // arbitration happens this cycle
  logic win;                // winner of this cycle's arbitration (1 = D)
  logic capture;            // mem_rdata is valid this cycle
  logic f_ready_nxt, d_ready_nxt, mem_en_nxt, mem_we_nxt, busy_nxt;

  assign grant   = (state == IDLE) && (f_req || d_req);
  assign win     = (f_req && d_req) ? ~last_grant : d_req;
  assign capture = (state == WAIT) && (cnt == '0);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (f_req || d_req) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (cnt == '0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: outputs are registered, so their next values are derived
  // from the next state; grant_sel already names the owner during RESP.
  always_comb begin
    f_ready_nxt = (state_nxt == RESP) && !grant_sel;
    d_ready_nxt = (state_nxt == RESP) &&  grant_sel;
    mem_en_nxt  = (state_nxt == ISSUE);
    mem_we_nxt  = grant && win && d_we;
    busy_nxt    = (state_nxt != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_ready    <= 1'b0;
      d_ready    <= 1'b0;
      f_rdata    <= '0;
      d_rdata    <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      grant_sel  <= 1'b0;
      busy       <= 1'b0;
      last_grant <= 1'b1;
      we_q       <= 1'b0;
      cnt        <= '0;
    end else begin
      f_ready <= f_ready_nxt;
      d_ready <= d_ready_nxt;
      mem_en  <= mem_en_nxt;
      mem_we  <= mem_we_nxt;
      busy    <= busy_nxt;
      // Address/data are latched at the grant and held until the next grant,
      // so they double as the ISSUE-cycle memory drive.
      if (grant) begin
        mem_addr   <= win ? d_addr : f_addr;
        mem_wdata  <= win ? d_wdata : '0;
        grant_sel  <= win;
        last_grant <= win;
        we_q       <= win && d_we;
      end
      if (state == ISSUE)                  cnt <= CNT_LOAD;
      else if (state == WAIT && cnt != '0) cnt <= cnt - 3'd1;
      if (capture && !we_q) begin
        if (grant_sel) d_rdata <= mem_rdata;
        else           f_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_imem_dmem_port_arbiter.sv
// Testbench for imem_dmem_port_arbiter: two instances (MEM_LAT = 1 and 3)
// driven by random requesters and checked every cycle against a
// transaction-level reference model (grant cycle g -> ISSUE at g+1,
// read data valid at g+1+LAT, ready at g+2+LAT, next arbitration g+3+LAT).
module tb_imem_dmem_port_arbiter;

  logic clk;
  logic rst_n;
  bit   both_hold;
  int   checks;
  int   failures;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_lat
    localparam int LAT = (gi == 0) ? 1 : 3;

    logic        f_req, d_req, d_we, f_ready, d_ready, mem_en, mem_we, grant_sel, busy;
    logic [31:0] f_addr, d_addr, d_wdata, f_rdata, d_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    imem_dmem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(LAT)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .f_req(f_req), .f_addr(f_addr), .f_ready(f_ready), .f_rdata(f_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ready(d_ready), .d_rdata(d_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .grant_sel(grant_sel), .busy(busy)
    );

    // Reference model: the single in-flight transaction plus held outputs
    int          cyc, g, free_at;
    bit          act, win, we, last_grant, e_gsel;
    logic [31:0] addr, wdata, rword, e_addr, e_wdata, e_frd, e_drd;
    string       pfx;

    task automatic model_reset();
      act = 0; last_grant = 1; free_at = 0; e_gsel = 0;
      e_addr = '0; e_wdata = '0; e_frd = '0; e_drd = '0;
    endtask

    // Asynchronous reset must clear every output without waiting for a clock
    always @(negedge rst_n) begin
      #1;
      check_eq({pfx, "_rst_f_ready"},   f_ready,   0);
      check_eq({pfx, "_rst_d_ready"},   d_ready,   0);
      check_eq({pfx, "_rst_f_rdata"},   f_rdata,   0);
      check_eq({pfx, "_rst_d_rdata"},   d_rdata,   0);
      check_eq({pfx, "_rst_mem_en"},    mem_en,    0);
      check_eq({pfx, "_rst_mem_we"},    mem_we,    0);
      check_eq({pfx, "_rst_mem_addr"},  mem_addr,  0);
      check_eq({pfx, "_rst_mem_wdata"}, mem_wdata, 0);
      check_eq({pfx, "_rst_grant_sel"}, grant_sel, 0);
      check_eq({pfx, "_rst_busy"},      busy,      0);
    end

    initial begin
      bit f_rdy_e, d_rdy_e, f_granted, d_granted, en_e;
      pfx = $sformatf("L%0d", LAT);
      f_req = 0; d_req = 0; d_we = 0; f_addr = '0; d_addr = '0; d_wdata = '0;
      mem_rdata = '0; cyc = 0; g = 0;
      addr = '0; wdata = '0; rword = '0;
      model_reset();
      forever begin
        @(negedge clk);
        cyc++;
        if (!rst_n) begin
          // Requests held through reset: first arbitration afterwards is a tie
          model_reset();
          f_req = 1; f_addr = $urandom;
          d_req = 1; d_addr = $urandom; d_we = 1'($urandom_range(0, 1)); d_wdata = $urandom;
          continue;
        end

        if (act && cyc == g + 1) begin
          e_addr = addr; e_wdata = wdata; e_gsel = win;
        end
        if (act && cyc == g + 2 + LAT && !we) begin
          if (win) e_drd = rword;
          else     e_frd = rword;
        end

        en_e    = act && cyc == g + 1;
        f_rdy_e = act && cyc == g + 2 + LAT && !win;
        d_rdy_e = act && cyc == g + 2 + LAT &&  win;
        check_eq({pfx, "_f_ready"},   f_ready,   f_rdy_e);
        check_eq({pfx, "_d_ready"},   d_ready,   d_rdy_e);
        check_eq({pfx, "_mem_en"},    mem_en,    en_e);
        check_eq({pfx, "_mem_we"},    mem_we,    en_e && we);
        check_eq({pfx, "_mem_addr"},  mem_addr,  e_addr);
        check_eq({pfx, "_mem_wdata"}, mem_wdata, e_wdata);
        check_eq({pfx, "_grant_sel"}, grant_sel, e_gsel);
        check_eq({pfx, "_busy"},      busy,      act && cyc >= g + 1 && cyc <= g + 2 + LAT);
        check_eq({pfx, "_f_rdata"},   f_rdata,   e_frd);
        check_eq({pfx, "_d_rdata"},   d_rdata,   e_drd);

        // Memory: valid word only in the cycle it is due, noise otherwise
        if (act && cyc == g + 1 + LAT && !we) mem_rdata = rword;
        else                                  mem_rdata = $urandom;

        // Requesters
        f_granted = act && !win && cyc <= g + 2 + LAT;
        d_granted = act &&  win && cyc <= g + 2 + LAT;
        if (both_hold) begin
          if (!f_req || f_rdy_e) f_addr = $urandom;
          f_req = 1;
        end else if (f_rdy_e) begin
          f_req = 1'($urandom_range(0, 1)); f_addr = $urandom;
        end else if (!f_req) begin
          if ($urandom_range(0, 9) < 4) begin f_req = 1; f_addr = $urandom; end
        end else if (f_granted) begin
          if ($urandom_range(0, 9) < 2) f_req = 0;
          f_addr = $urandom;
        end
        if (both_hold) begin
          if (!d_req || d_rdy_e) begin
            d_addr = $urandom; d_we = 1'($urandom_range(0, 1)); d_wdata = $urandom;
          end
          d_req = 1;
        end else if (d_rdy_e || !d_req) begin
          if (d_rdy_e || $urandom_range(0, 9) < 4) begin
            d_req = d_rdy_e ? 1'($urandom_range(0, 1)) : 1'b1;
            d_addr = $urandom; d_we = 1'($urandom_range(0, 1)); d_wdata = $urandom;
          end
        end else if (d_granted) begin
          if ($urandom_range(0, 9) < 2) d_req = 0;
          d_addr = $urandom; d_we = 1'($urandom_range(0, 1)); d_wdata = $urandom;
        end

        // Arbitration as the sequencer sees the inputs of this idle cycle
        if (cyc >= free_at && (f_req || d_req)) begin
          win        = (f_req && d_req) ? !last_grant : d_req;
          act        = 1;
          g          = cyc;
          we         = win && d_we;
          addr       = win ? d_addr : f_addr;
          wdata      = win ? d_wdata : '0;
          rword      = $urandom;
          last_grant = win;
          free_at    = cyc + 3 + LAT;
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; both_hold = 1; checks = 0; failures = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (30) @(posedge clk);
    both_hold = 0;
    repeat (400) @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1; both_hold = 1;
    repeat (20) @(posedge clk);
    both_hold = 0;
    repeat (300) @(posedge clk);
    #3 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1; both_hold = 1;
    repeat (12) @(posedge clk);
    both_hold = 0;
    repeat (200) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
